// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared FSM encodings and fetch constants for the PC redirect unit
package pc_redirect_unit_pkg;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_redirect_if.sv
// pc_redirect_if: redirect request, stall inputs and fetch/flush outputs of the PC redirect unit
// master drives requests and stalls, slave (the unit) drives PC, fetch enable, flushes and status
interface pc_redirect_if #(parameter int CNT_W = 16);
  logic PC_MUX_CONTROL;
  logic [31:0] BRANCH_OR_JUMP_ADDR;
  logic IMEM_BUSYWAIT;
  logic DMEM_BUSYWAIT;
  logic HAZARD_STALL;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic IMEM_READ;
  logic IF_ID_FLUSH;
  logic ID_EX_FLUSH;
  logic ADDR_MISALIGNED;
  logic [CNT_W-1:0] REDIRECT_COUNT;
  modport master (
    output PC_MUX_CONTROL, BRANCH_OR_JUMP_ADDR, IMEM_BUSYWAIT, DMEM_BUSYWAIT, HAZARD_STALL,
    input PC, PC_PLUS_4, IMEM_READ, IF_ID_FLUSH, ID_EX_FLUSH, ADDR_MISALIGNED, REDIRECT_COUNT
  );
  modport slave (
    input PC_MUX_CONTROL, BRANCH_OR_JUMP_ADDR, IMEM_BUSYWAIT, DMEM_BUSYWAIT, HAZARD_STALL,
    output PC, PC_PLUS_4, IMEM_READ, IF_ID_FLUSH, ID_EX_FLUSH, ADDR_MISALIGNED, REDIRECT_COUNT
  );
endinterface

// File: rtl/pc_redirect_unit_pc_adder.sv
// pc_adder: next sequential fetch address, wraps modulo 2^32
// i_pc: current PC; o_pc_plus_4: i_pc + instruction size
module pc_adder
  import pc_redirect_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_plus_4
);
  assign o_pc_plus_4 = i_pc + INSTR_BYTES;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies EX redirects (deferred across memory stalls), flushes IF/ID and ID/EX
// CLK/RESET: clock and sync active-high reset; bus: redirect request, stalls in; PC, fetch enable, flushes, status out
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RESET,
  pc_redirect_if.slave bus
);
  logic [0:0] r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic r_mis;
  logic w_stall;
  logic w_apply;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus_4;
  pc_adder u_pc_adder (.i_pc(r_pc), .o_pc_plus_4(w_pc_plus_4));
  assign w_stall = bus.IMEM_BUSYWAIT | bus.DMEM_BUSYWAIT;
  // a live request always beats a deferred one; a stall postpones both
  assign w_apply = ~RESET & ~w_stall & (bus.PC_MUX_CONTROL | (r_state == ST_HOLD));
  assign w_target = bus.PC_MUX_CONTROL ? bus.BRANCH_OR_JUMP_ADDR : r_pend;
  assign bus.PC = r_pc;
  assign bus.PC_PLUS_4 = w_pc_plus_4;
  assign bus.IMEM_READ = ~RESET;
  assign bus.IF_ID_FLUSH = w_apply;
  assign bus.ID_EX_FLUSH = w_apply;
  assign bus.ADDR_MISALIGNED = r_mis;
  assign bus.REDIRECT_COUNT = r_cnt;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_RUN;
      r_pc <= RESET_PC;
      r_pend <= '0;
      r_cnt <= '0;
      r_mis <= 1'b0;
    end else begin
      r_state <= w_stall ? (bus.PC_MUX_CONTROL ? ST_HOLD : r_state) : ST_RUN;
      if (w_stall && bus.PC_MUX_CONTROL) r_pend <= bus.BRANCH_OR_JUMP_ADDR;
      // bit0 dropped silently (JALR), bit1 reported as misaligned
      r_pc <= w_apply ? (w_target & 32'hFFFF_FFFC) : (w_stall || bus.HAZARD_STALL) ? r_pc : w_pc_plus_4;
      r_cnt <= r_cnt + CNT_W'(w_apply);
      r_mis <= w_apply & w_target[1];
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic CLK;
  logic RESET;
  int checks;
  int errs;
  pc_redirect_if #(.CNT_W(16)) bus ();
  pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    bus.PC_MUX_CONTROL = 1'b0;
    bus.BRANCH_OR_JUMP_ADDR = 32'h0;
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.DMEM_BUSYWAIT = 1'b0;
    bus.HAZARD_STALL = 1'b0;
  endtask
  task automatic test_reset();
    logic [31:0] exp_pc;
    idle();
    RESET = 1'b1;
    step();
    step();
    checks++; if (bus.PC !== 32'h0) begin errs++; $display("FAIL reset_pc got %h exp %h", bus.PC, 32'h0); end
    checks++; if (bus.IMEM_READ !== 1'b0) begin errs++; $display("FAIL reset_imem_read got %b exp 0", bus.IMEM_READ); end
    checks++; if (bus.IF_ID_FLUSH !== 1'b0 || bus.ID_EX_FLUSH !== 1'b0) begin errs++; $display("FAIL reset_flush got %b%b exp 00", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    checks++; if (bus.REDIRECT_COUNT !== 16'h0 || bus.ADDR_MISALIGNED !== 1'b0) begin errs++; $display("FAIL reset_status got cnt %h mis %b exp 0 0", bus.REDIRECT_COUNT, bus.ADDR_MISALIGNED); end
    RESET = 1'b0;
    #1;
    checks++; if (bus.IMEM_READ !== 1'b1) begin errs++; $display("FAIL run_imem_read got %b exp 1", bus.IMEM_READ); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc += 32'h4;
      checks++; if (bus.PC !== exp_pc) begin errs++; $display("FAIL seq_pc[%0d] got %h exp %h", i, bus.PC, exp_pc); end
      checks++; if (bus.IF_ID_FLUSH !== 1'b0 || bus.ID_EX_FLUSH !== 1'b0) begin errs++; $display("FAIL seq_flush[%0d] got %b%b exp 00", i, bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    end
    checks++; if (bus.PC_PLUS_4 !== 32'h10) begin errs++; $display("FAIL pc_plus_4 got %h exp 10", bus.PC_PLUS_4); end
  endtask
  task automatic test_redirect();
    step();
    checks++; if (bus.PC !== 32'h10) begin errs++; $display("FAIL redir_start_pc got %h exp 10", bus.PC); end
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h200;
    #1;
    checks++; if (bus.IF_ID_FLUSH !== 1'b1 || bus.ID_EX_FLUSH !== 1'b1) begin errs++; $display("FAIL redir_flush got %b%b exp 11", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    #1;
    checks++; if (bus.PC !== 32'h200) begin errs++; $display("FAIL redir_pc got %h exp 200", bus.PC); end
    checks++; if (bus.REDIRECT_COUNT !== 16'd1) begin errs++; $display("FAIL redir_cnt got %h exp 1", bus.REDIRECT_COUNT); end
    checks++; if (bus.ADDR_MISALIGNED !== 1'b0) begin errs++; $display("FAIL redir_mis got %b exp 0", bus.ADDR_MISALIGNED); end
    checks++; if (bus.IF_ID_FLUSH !== 1'b0) begin errs++; $display("FAIL redir_flush_after got %b exp 0", bus.IF_ID_FLUSH); end
  endtask
  task automatic test_stall_defer();
    bus.DMEM_BUSYWAIT = 1'b1;
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h300;
    #1;
    checks++; if (bus.IF_ID_FLUSH !== 1'b0 || bus.ID_EX_FLUSH !== 1'b0) begin errs++; $display("FAIL defer_flush_req got %b%b exp 00", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.PC !== 32'h200 || bus.IF_ID_FLUSH !== 1'b0 || bus.ID_EX_FLUSH !== 1'b0) begin errs++; $display("FAIL defer_hold[%0d] got pc %h flush %b%b exp 200 00", i, bus.PC, bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
      step();
    end
    bus.DMEM_BUSYWAIT = 1'b0;
    #1;
    checks++; if (bus.IF_ID_FLUSH !== 1'b1 || bus.ID_EX_FLUSH !== 1'b1) begin errs++; $display("FAIL defer_flush_release got %b%b exp 11", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    step();
    checks++; if (bus.PC !== 32'h300) begin errs++; $display("FAIL defer_pc got %h exp 300", bus.PC); end
    checks++; if (bus.REDIRECT_COUNT !== 16'd2) begin errs++; $display("FAIL defer_cnt got %h exp 2", bus.REDIRECT_COUNT); end
    checks++; if (bus.IF_ID_FLUSH !== 1'b0) begin errs++; $display("FAIL defer_single got %b exp 0", bus.IF_ID_FLUSH); end
  endtask
  task automatic test_latest_wins();
    bus.IMEM_BUSYWAIT = 1'b1;
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h300;
    step();
    bus.BRANCH_OR_JUMP_ADDR = 32'h400;
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    step();
    checks++; if (bus.PC !== 32'h300) begin errs++; $display("FAIL latest_hold_pc got %h exp 300", bus.PC); end
    bus.IMEM_BUSYWAIT = 1'b0;
    step();
    checks++; if (bus.PC !== 32'h400) begin errs++; $display("FAIL latest_pc got %h exp 400", bus.PC); end
    checks++; if (bus.REDIRECT_COUNT !== 16'd3) begin errs++; $display("FAIL latest_cnt got %h exp 3", bus.REDIRECT_COUNT); end
    step();
    checks++; if (bus.PC !== 32'h404 || bus.REDIRECT_COUNT !== 16'd3) begin errs++; $display("FAIL latest_after got pc %h cnt %h exp 404 3", bus.PC, bus.REDIRECT_COUNT); end
  endtask
  task automatic test_hazard();
    bus.HAZARD_STALL = 1'b1;
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h80;
    #1;
    checks++; if (bus.IF_ID_FLUSH !== 1'b1 || bus.ID_EX_FLUSH !== 1'b1) begin errs++; $display("FAIL hazard_redir_flush got %b%b exp 11", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    #1;
    checks++; if (bus.PC !== 32'h80 || bus.REDIRECT_COUNT !== 16'd4) begin errs++; $display("FAIL hazard_redir_pc got pc %h cnt %h exp 80 4", bus.PC, bus.REDIRECT_COUNT); end
    checks++; if (bus.IF_ID_FLUSH !== 1'b0 || bus.ID_EX_FLUSH !== 1'b0) begin errs++; $display("FAIL hazard_only_flush got %b%b exp 00", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    step();
    step();
    checks++; if (bus.PC !== 32'h80) begin errs++; $display("FAIL hazard_only_pc got %h exp 80", bus.PC); end
    bus.HAZARD_STALL = 1'b0;
    step();
    checks++; if (bus.PC !== 32'h84) begin errs++; $display("FAIL hazard_release_pc got %h exp 84", bus.PC); end
  endtask
  task automatic test_misaligned();
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h102;
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    checks++; if (bus.PC !== 32'h100 || bus.ADDR_MISALIGNED !== 1'b1) begin errs++; $display("FAIL mis_set got pc %h mis %b exp 100 1", bus.PC, bus.ADDR_MISALIGNED); end
    step();
    checks++; if (bus.PC !== 32'h104 || bus.ADDR_MISALIGNED !== 1'b0) begin errs++; $display("FAIL mis_pulse got pc %h mis %b exp 104 0", bus.PC, bus.ADDR_MISALIGNED); end
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h101;
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    checks++; if (bus.PC !== 32'h100 || bus.ADDR_MISALIGNED !== 1'b0) begin errs++; $display("FAIL bit0_ignored got pc %h mis %b exp 100 0", bus.PC, bus.ADDR_MISALIGNED); end
    checks++; if (bus.REDIRECT_COUNT !== 16'd6) begin errs++; $display("FAIL bit0_cnt got %h exp 6", bus.REDIRECT_COUNT); end
  endtask
  task automatic test_back_to_back();
    bus.PC_MUX_CONTROL = 1'b1;
    for (int i = 0; i < 65529; i++) begin
      bus.BRANCH_OR_JUMP_ADDR = i[0] ? 32'h40 : 32'h80;
      step();
    end
    checks++; if (bus.REDIRECT_COUNT !== 16'hFFFF) begin errs++; $display("FAIL cnt_full got %h exp ffff", bus.REDIRECT_COUNT); end
    bus.BRANCH_OR_JUMP_ADDR = 32'hFFFF_FFFC;
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    checks++; if (bus.REDIRECT_COUNT !== 16'h0) begin errs++; $display("FAIL cnt_wrap got %h exp 0", bus.REDIRECT_COUNT); end
    checks++; if (bus.PC !== 32'hFFFF_FFFC || bus.PC_PLUS_4 !== 32'h0) begin errs++; $display("FAIL pc_top got pc %h plus4 %h exp fffffffc 0", bus.PC, bus.PC_PLUS_4); end
    step();
    checks++; if (bus.PC !== 32'h0 || bus.ADDR_MISALIGNED !== 1'b0) begin errs++; $display("FAIL pc_wrap got pc %h mis %b exp 0 0", bus.PC, bus.ADDR_MISALIGNED); end
  endtask
  task automatic test_reset_in_hold();
    step();
    step();
    bus.IMEM_BUSYWAIT = 1'b1;
    bus.PC_MUX_CONTROL = 1'b1;
    bus.BRANCH_OR_JUMP_ADDR = 32'h500;
    step();
    bus.PC_MUX_CONTROL = 1'b0;
    RESET = 1'b1;
    bus.IMEM_BUSYWAIT = 1'b0;
    #1;
    checks++; if (bus.IF_ID_FLUSH !== 1'b0 || bus.IMEM_READ !== 1'b0) begin errs++; $display("FAIL hold_reset_outputs got flush %b read %b exp 0 0", bus.IF_ID_FLUSH, bus.IMEM_READ); end
    step();
    RESET = 1'b0;
    #1;
    checks++; if (bus.PC !== 32'h0 || bus.REDIRECT_COUNT !== 16'h0) begin errs++; $display("FAIL hold_reset_state got pc %h cnt %h exp 0 0", bus.PC, bus.REDIRECT_COUNT); end
    checks++; if (bus.IF_ID_FLUSH !== 1'b0 || bus.ID_EX_FLUSH !== 1'b0) begin errs++; $display("FAIL hold_discard_flush got %b%b exp 00", bus.IF_ID_FLUSH, bus.ID_EX_FLUSH); end
    step();
    checks++; if (bus.PC !== 32'h4 || bus.REDIRECT_COUNT !== 16'h0) begin errs++; $display("FAIL hold_discard_pc got pc %h cnt %h exp 4 0", bus.PC, bus.REDIRECT_COUNT); end
  endtask
  initial begin
    checks = 0;
    errs = 0;
    test_reset();
    test_redirect();
    test_stall_defer();
    test_latest_wins();
    test_hazard();
    test_misaligned();
    test_back_to_back();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
